// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared types and constants for the fetch/execute control sequencer:
//   ctrl_t      - packed word of active-low strobes consumed by register_gp (a),
//                 register_xfer (xfer), register_addr (pcra0) and memory
//   CTRL_W      - width of ctrl_t
//   CTRL_IDLE   - all strobes released (all ones)
//   opcode_t    - defined opcodes
//   seq_state_t - sequencer states
//   op_steps()  - number of exec microsteps an opcode runs
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam int WIDTH_MAIN = 8;
    localparam int STEP_W     = 2;

    typedef struct packed {
        logic a_load_main;
        logic a_assert_main;
        logic a_assert_lhs;
        logic a_assert_rhs;
        logic xfer_loadlow_main;
        logic xfer_loadhigh_main;
        logic xfer_assert_addr;
        logic xfer_assert_xfer;
        logic pcra0_assert_addr;
        logic pcra0_inc;
        logic pcra0_dec;
        logic pcra0_load_xfer;
        logic mem_assert_main;
        logic mem_load_main;
    } ctrl_t;

    localparam int    CTRL_W    = $bits(ctrl_t);
    localparam ctrl_t CTRL_IDLE = ctrl_t'({CTRL_W{1'b1}});

    typedef enum logic [WIDTH_MAIN-1:0] {
        OP_NOP      = 8'h00,
        OP_LDA_IMM  = 8'h01,
        OP_LDXL_IMM = 8'h02,
        OP_LDXH_IMM = 8'h03,
        OP_JMPX     = 8'h04,
        OP_STAX     = 8'h05,
        OP_LDAX     = 8'h06,
        OP_HLT      = 8'hFF
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        INC   = 3'd2,
        EXEC  = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    // Exec microstep count; zero means the opcode ends right after INC.
    function automatic logic [STEP_W:0] op_steps(input logic [WIDTH_MAIN-1:0] op);
        logic [STEP_W:0] n;
        case (op)
            OP_LDA_IMM, OP_LDXL_IMM, OP_LDXH_IMM: n = 3'd2;
            OP_JMPX, OP_STAX, OP_LDAX:            n = 3'd1;
            default:                              n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// ---------------------------------------------------------------------------
// control_sequencer_if
// Bus bundle between the control sequencer and its datapath/memory side.
//   main_in   - resolved main bus (opcode / immediate source)
//   mem_ready - memory completes the current access this cycle
//   run       - keep fetching when 1
//   step_req  - single-step request (only with SINGLE_STEP_EN defined)
//   ctrl_n    - active-low strobe word (ctrl_t)
//   ir        - instruction register
//   step      - current exec microstep
//   halted    - HLT executed
//   illegal   - sticky undefined-opcode flag
// Modports: master = sequencer side, slave = datapath/environment side.
// ---------------------------------------------------------------------------
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [WIDTH_MAIN-1:0] main_in;
    logic                  mem_ready;
    logic                  run;
`ifdef SINGLE_STEP_EN
    logic                  step_req;
`endif
    ctrl_t                 ctrl_n;
    logic [WIDTH_MAIN-1:0] ir;
    logic [STEP_W-1:0]     step;
    logic                  halted;
    logic                  illegal;

`ifdef SINGLE_STEP_EN
    modport master (input main_in, mem_ready, run, step_req,
                    output ctrl_n, ir, step, halted, illegal);
    modport slave  (output main_in, mem_ready, run, step_req,
                    input ctrl_n, ir, step, halted, illegal);
`else
    modport master (input main_in, mem_ready, run,
                    output ctrl_n, ir, step, halted, illegal);
    modport slave  (output main_in, mem_ready, run,
                    input ctrl_n, ir, step, halted, illegal);
`endif

endinterface

// File: rtl/control_sequencer_ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Combinational microcode table: (opcode, exec step) -> strobe word + flags.
//   i_opcode     - instruction register contents
//   i_step       - exec microstep to decode
//   o_ctrl       - active-low strobe word for that step
//   o_is_mem     - step accesses memory (stretches on mem_ready=0)
//   o_is_last    - step is the final exec step of the opcode
//   o_is_illegal - opcode is undefined
//   o_is_halt    - opcode is HLT
// ---------------------------------------------------------------------------
import cpu_ctrl_pkg::*;

module ctrl_decode (
    input  logic [WIDTH_MAIN-1:0] i_opcode,
    input  logic [STEP_W-1:0]     i_step,
    output ctrl_t                 o_ctrl,
    output logic                  o_is_mem,
    output logic                  o_is_last,
    output logic                  o_is_illegal,
    output logic                  o_is_halt
);

    // Microcode lookup
    always_comb begin
        o_ctrl       = CTRL_IDLE;
        o_is_mem     = 1'b0;
        o_is_illegal = 1'b0;
        o_is_halt    = 1'b0;
        case (i_opcode)
            OP_LDA_IMM, OP_LDXL_IMM, OP_LDXH_IMM: begin
                if (i_step == {STEP_W{1'b0}}) begin
                    // Immediate byte sits at pcra0 (already bumped past the opcode).
                    o_ctrl.pcra0_assert_addr = 1'b0;
                    o_ctrl.mem_assert_main   = 1'b0;
                    o_is_mem                 = 1'b1;
                    case (i_opcode)
                        OP_LDA_IMM:  o_ctrl.a_load_main        = 1'b0;
                        OP_LDXL_IMM: o_ctrl.xfer_loadlow_main  = 1'b0;
                        default:     o_ctrl.xfer_loadhigh_main = 1'b0;
                    endcase
                end else begin
                    o_ctrl.pcra0_inc = 1'b0;
                end
            end
            OP_JMPX: begin
                o_ctrl.xfer_assert_xfer = 1'b0;
                o_ctrl.pcra0_load_xfer  = 1'b0;
            end
            OP_STAX: begin
                o_ctrl.xfer_assert_addr = 1'b0;
                o_ctrl.a_assert_main    = 1'b0;
                o_ctrl.mem_load_main    = 1'b0;
                o_is_mem                = 1'b1;
            end
            OP_LDAX: begin
                o_ctrl.xfer_assert_addr = 1'b0;
                o_ctrl.mem_assert_main  = 1'b0;
                o_ctrl.a_load_main      = 1'b0;
                o_is_mem                = 1'b1;
            end
            OP_HLT:  o_is_halt    = 1'b1;
            OP_NOP:  o_is_illegal = 1'b0;
            default: o_is_illegal = 1'b1;
        endcase
        o_is_last = (({1'b0, i_step} + 3'd1) >= op_steps(i_opcode));
    end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Fetch/execute sequencer driving the active-low strobes of a, xfer, pcra0
// and memory. Fetches an opcode at pcra0, bumps pcra0, then runs the opcode's
// fixed microsequence, one step per clock; memory steps stretch on wait states.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low
//   bus   - control_sequencer_if.master (main_in, mem_ready, run, ctrl_n,
//           ir, step, halted, illegal; step_req with SINGLE_STEP_EN)
// Configuration macro: SINGLE_STEP_EN - IDLE->FETCH only on a rising edge of
//   step_req, one instruction per edge, run ignored.
// ---------------------------------------------------------------------------
import cpu_ctrl_pkg::*;

module control_sequencer (
    input  logic                 clk,
    input  logic                 reset,
    control_sequencer_if.master  bus
);

    seq_state_t            r_state;
    seq_state_t            w_state_nxt;
    logic [STEP_W-1:0]     r_step;
    logic [STEP_W-1:0]     w_step_nxt;
    logic [WIDTH_MAIN-1:0] r_ir;
    ctrl_t                 r_ctrl;
    ctrl_t                 w_ctrl_nxt;
    logic                  r_halted;
    logic                  r_illegal;
    // Properties of the step currently executing, captured with its ctrl word.
    logic                  r_mem;
    logic                  r_last;

    ctrl_t                 w_dec_ctrl;
    logic                  w_dec_mem;
    logic                  w_dec_last;
    logic                  w_dec_illegal;
    logic                  w_dec_halt;
    logic                  w_go;
    logic                  w_cont;

`ifdef SINGLE_STEP_EN
    logic r_step_req_d1;

    // Delay step_req to detect its rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_step_req_d1 <= 1'b0;
        end else begin
            r_step_req_d1 <= bus.step_req;
        end
    end

    assign w_go   = bus.step_req & ~r_step_req_d1;
    assign w_cont = 1'b0;
`else
    assign w_go   = bus.run;
    assign w_cont = bus.run;
`endif

    // Decode the step that will execute next, so ctrl_n can come from flops.
    ctrl_decode u_decode (
        .i_opcode     (r_ir),
        .i_step       (w_step_nxt),
        .o_ctrl       (w_dec_ctrl),
        .o_is_mem     (w_dec_mem),
        .o_is_last    (w_dec_last),
        .o_is_illegal (w_dec_illegal),
        .o_is_halt    (w_dec_halt)
    );

    // Next microstep: advances in EXEC unless a memory step is stalled
    always_comb begin
        w_step_nxt = r_step;
        case (r_state)
            EXEC: begin
                if (r_mem && !bus.mem_ready) begin
                    w_step_nxt = r_step;
                end else if (r_last) begin
                    w_step_nxt = {STEP_W{1'b0}};
                end else begin
                    w_step_nxt = r_step + 2'd1;
                end
            end
            default: w_step_nxt = {STEP_W{1'b0}};
        endcase
    end

    // Next state and the strobe word that state will drive
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_nxt  = CTRL_IDLE;
        case (r_state)
            IDLE: begin
                if (w_go) begin
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    w_state_nxt = INC;
                end else begin
                    w_state_nxt = FETCH;
                end
            end
            INC: begin
                if (w_dec_halt) begin
                    w_state_nxt = HALT;
                end else if (op_steps(r_ir) == 3'd0) begin
                    w_state_nxt = w_cont ? FETCH : IDLE;
                end else begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (r_mem && !bus.mem_ready) begin
                    w_state_nxt = EXEC;
                end else if (r_last) begin
                    w_state_nxt = w_cont ? FETCH : IDLE;
                end else begin
                    w_state_nxt = EXEC;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase

        case (w_state_nxt)
            FETCH: begin
                w_ctrl_nxt.pcra0_assert_addr = 1'b0;
                w_ctrl_nxt.mem_assert_main   = 1'b0;
            end
            INC:     w_ctrl_nxt.pcra0_inc = 1'b0;
            EXEC:    w_ctrl_nxt = w_dec_ctrl;
            default: w_ctrl_nxt = CTRL_IDLE;
        endcase
    end

    // State, microstep, IR, flags and output strobe registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_step    <= {STEP_W{1'b0}};
            r_ir      <= {WIDTH_MAIN{1'b0}};
            r_ctrl    <= CTRL_IDLE;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_mem     <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_mem   <= w_dec_mem;
            r_last  <= w_dec_last;
            if (r_state == FETCH && bus.mem_ready) begin
                r_ir <= bus.main_in;
            end
            if (r_state == INC && w_dec_halt) begin
                r_halted <= 1'b1;
            end
            if (r_state == INC && w_dec_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign bus.ctrl_n  = r_ctrl;
    assign bus.ir      = r_ir;
    assign bus.step    = r_step;
    assign bus.halted  = r_halted;
    assign bus.illegal = r_illegal;

endmodule
